// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampled UART receiver, LSB-first, one-entry holding register.
// Define UART_RX_PARITY_EN to add one parity bit between the data bits and the stop bit.
module uart_rx_core #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  aresetn,
   input  logic                  baud_clock,
   input  logic                  rx,
   input  logic                  odd_n_even,
   input  logic                  read_ack,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  data_ready,
   output logic                  framing_err,
   output logic                  parity_err,
   output logic                  overflow
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;

   localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

   state_t                r_state;
   state_t                w_next;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                  w_rx_s;
   logic [3:0]            r_sample_cnt;
   logic [3:0]            r_bit_cnt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  w_parity_bad;
   logic                  w_tick_mid;
   logic                  w_tick_end;
   logic                  w_last_bit;
   logic                  w_commit;

   assign w_rx_s = r_sync[SYNC_STAGES-1];

   // Metastability synchronizer for rx, resets to the idle-high line level
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
      end
   end

   // State register
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Tick decodes shared by the next-state logic and the datapath
   always_comb begin
      w_tick_mid = baud_clock && (r_sample_cnt == 4'd7);
      w_tick_end = baud_clock && (r_sample_cnt == 4'd15);
      w_last_bit = (r_bit_cnt == LAST_BIT);
      w_commit   = w_tick_end && (r_state == S_STOP);
   end

   // Next-state logic; every transition is qualified by a baud tick
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (baud_clock && !w_rx_s) w_next = S_START;
            else                       w_next = S_IDLE;
         end
         S_START: begin
            if (w_tick_mid) w_next = w_rx_s ? S_IDLE : S_DATA;
            else            w_next = S_START;
         end
         S_DATA: begin
`ifdef UART_RX_PARITY_EN
            if (w_tick_end && w_last_bit) w_next = S_PARITY;
`else
            if (w_tick_end && w_last_bit) w_next = S_STOP;
`endif
            else                          w_next = S_DATA;
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (w_tick_end) w_next = S_STOP;
            else            w_next = S_PARITY;
         end
`endif
         S_STOP: begin
            if (w_commit) w_next = w_rx_s ? S_IDLE : S_BREAK;
            else          w_next = S_STOP;
         end
         // Holding here stops a stuck-low line from looking like endless start bits
         S_BREAK: begin
            if (baud_clock && w_rx_s) w_next = S_IDLE;
            else                      w_next = S_BREAK;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Oversample counter, bit counter and LSB-first shift register
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_sample_cnt <= 4'd0;
         r_bit_cnt    <= 4'd0;
         r_shift      <= '0;
      end else if (baud_clock) begin
         case (r_state)
            S_IDLE, S_BREAK: r_sample_cnt <= 4'd0;
            S_START: begin
               if (r_sample_cnt == 4'd7) begin
                  r_sample_cnt <= 4'd0;
                  r_bit_cnt    <= 4'd0;
               end else begin
                  r_sample_cnt <= r_sample_cnt + 4'd1;
               end
            end
            S_DATA: begin
               if (r_sample_cnt == 4'd15) begin
                  r_shift      <= {w_rx_s, r_shift[DATA_WIDTH-1:1]};
                  r_sample_cnt <= 4'd0;
                  r_bit_cnt    <= r_bit_cnt + 4'd1;
               end else begin
                  r_sample_cnt <= r_sample_cnt + 4'd1;
               end
            end
            default: r_sample_cnt <= r_sample_cnt + 4'd1;
         endcase
      end
   end

`ifdef UART_RX_PARITY_EN
   logic r_parity_bad;

   // Bad when the ones count over data+parity disagrees with the selected sense
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_parity_bad <= 1'b0;
      end else if (w_tick_end && (r_state == S_PARITY)) begin
         r_parity_bad <= (^r_shift) ^ w_rx_s ^ odd_n_even;
      end
   end

   assign w_parity_bad = r_parity_bad;
`else
   logic w_unused_odd_n_even;

   assign w_unused_odd_n_even = odd_n_even;
   assign w_parity_bad        = 1'b0;
`endif

   // Holding register: a commit overrides a simultaneous read_ack
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         rx_data     <= '0;
         data_ready  <= 1'b0;
         framing_err <= 1'b0;
         parity_err  <= 1'b0;
         overflow    <= 1'b0;
      end else if (w_commit) begin
         rx_data     <= r_shift;
         framing_err <= ~w_rx_s;
         parity_err  <= w_parity_bad;
         data_ready  <= 1'b1;
         if (read_ack) begin
            overflow <= 1'b0;
         end else if (data_ready) begin
            overflow <= 1'b1;
         end
      end else if (read_ack) begin
         data_ready <= 1'b0;
         overflow   <= 1'b0;
      end
   end

endmodule
